// File: rtl/mem_resp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_resp_pkg : shared states, op encoding and default sizes for mem_responder
// Revision     : 1.0
// ============================================================================
package mem_resp_pkg;

    localparam int c_DEF_LINES  = 8;
    localparam int c_DEF_ADDR_W = 22;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        BM_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage
`default_nettype wire

// File: rtl/mem_tag_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_tag_array : direct-mapped valid/tag/data store, one read and one write
//                 port; present only when MEM_RESP_CACHE_EN is defined
// Revision      : 1.0
// ============================================================================
`ifdef MEM_RESP_CACHE_EN
module mem_tag_array #(
    parameter int LINES  = 8,
    parameter int IDX_W  = $clog2(LINES),
    parameter int TAG_W  = 19,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    // Only the valid bits need reset; tag/data are qualified by them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule
`endif
`default_nettype wire

// File: rtl/mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_responder : MEM-stage responder with optional direct-mapped write-through
//                 cache (enabled by MEM_RESP_CACHE_EN) in front of backing memory
// Revision      : 1.0
// ============================================================================
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int LINES  = c_DEF_LINES,
    parameter int ADDR_W = c_DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       mem_data,
    output logic [31:0]       mem_result,
    output logic              cache_hit,
    output logic              busy,
    output logic              bm_req,
    output logic              bm_we,
    output logic [ADDR_W-1:0] bm_addr,
    output logic [31:0]       bm_wdata,
    input  logic [31:0]       bm_rdata,
    input  logic              bm_ack
);

    localparam int c_IDX_W = $clog2(LINES);
    localparam int c_TAG_W = ADDR_W - c_IDX_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    op_t               r_op;
    logic [31:0]       r_result;
    logic              w_lookup_hit;
    logic [31:0]       w_line_data;

`ifdef MEM_RESP_CACHE_EN
    logic               w_line_valid;
    logic [c_TAG_W-1:0] w_line_tag;
    logic               w_tag_match;
    logic               w_fill_en;
    logic [31:0]        w_fill_data;

    assign w_tag_match  = w_line_valid && (w_line_tag == r_addr[ADDR_W-1:c_IDX_W]);
    assign w_lookup_hit = (r_op == OP_RD) && w_tag_match;
    // Reads allocate; writes only refresh a line already holding this address.
    assign w_fill_en    = (r_state == BM_WAIT) && bm_ack && ((r_op == OP_RD) || w_tag_match);
    assign w_fill_data  = (r_op == OP_RD) ? bm_rdata : r_data;

    mem_tag_array #(
        .LINES  (LINES),
        .IDX_W  (c_IDX_W),
        .TAG_W  (c_TAG_W),
        .DATA_W (32)
    ) u_tag_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_idx   (r_addr[c_IDX_W-1:0]),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_wr_en    (w_fill_en),
        .i_wr_idx   (r_addr[c_IDX_W-1:0]),
        .i_wr_tag   (r_addr[ADDR_W-1:c_IDX_W]),
        .i_wr_data  (w_fill_data)
    );
`else
    assign w_lookup_hit = 1'b0;
    assign w_line_data  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (re || we) w_state_nxt = LOOKUP;
            LOOKUP:  w_state_nxt = w_lookup_hit ? RESP : BM_WAIT;
            BM_WAIT: if (bm_ack) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != IDLE);
        cache_hit = (r_state == RESP);
        bm_req    = (r_state == BM_WAIT);
        bm_we     = (r_state == BM_WAIT) && (r_op == OP_WR);
    end

    // Request is captured once at acceptance, so the bm_* fields stay stable in BM_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_data   <= '0;
            r_op     <= OP_RD;
            r_result <= '0;
        end else begin
            if ((r_state == IDLE) && (re || we)) begin
                r_addr <= addr;
                r_data <= mem_data;
                r_op   <= we ? OP_WR : OP_RD;
            end
            if ((r_state == LOOKUP) && w_lookup_hit) begin
                r_result <= w_line_data;
            end else if ((r_state == BM_WAIT) && bm_ack && (r_op == OP_RD)) begin
                r_result <= bm_rdata;
            end
        end
    end

    assign mem_result = r_result;
    assign bm_addr    = r_addr;
    assign bm_wdata   = r_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mem_responder : directed and randomized checks of mem_responder against a
//                    transaction-level cache/backing-memory model
// Revision         : 1.0
// ============================================================================
module tb_mem_responder;

    localparam int LINES  = 8;
    localparam int ADDR_W = 22;
`ifdef MEM_RESP_CACHE_EN
    localparam bit c_CACHE = 1'b1;
`else
    localparam bit c_CACHE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              re = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       mem_data = '0;
    logic [31:0]       bm_rdata = '0;
    logic              bm_ack = 1'b0;
    logic [31:0]       mem_result;
    logic              cache_hit;
    logic              busy;
    logic              bm_req;
    logic              bm_we;
    logic [ADDR_W-1:0] bm_addr;
    logic [31:0]       bm_wdata;

    mem_responder #(.LINES(LINES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .re(re), .we(we), .addr(addr), .mem_data(mem_data),
        .mem_result(mem_result), .cache_hit(cache_hit), .busy(busy), .bm_req(bm_req),
        .bm_we(bm_we), .bm_addr(bm_addr), .bm_wdata(bm_wdata), .bm_rdata(bm_rdata),
        .bm_ack(bm_ack)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int cnt_req = 0;
    int cnt_wreq = 0;
    int cnt_hit = 0;
    int hit_cyc = -1;

    // Expected outputs for the current cycle, set by the driver from the model.
    bit                chk_en = 1'b0;
    logic              e_busy = 1'b0;
    logic              e_hit = 1'b0;
    logic              e_req = 1'b0;
    logic              e_we = 1'b0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [31:0]       e_wdata = '0;
    logic [31:0]       e_result = '0;

    // Model cache: which full address each index holds, and its data.
    bit                mv [LINES];
    logic [ADDR_W-1:0] ma [LINES];
    logic [31:0]       md [LINES];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(e_busy));
            check("cache_hit", 32'(cache_hit), 32'(e_hit));
            check("bm_req", 32'(bm_req), 32'(e_req));
            check("mem_result", mem_result, e_result);
            if (e_req) begin
                check("bm_we", 32'(bm_we), 32'(e_we));
                check("bm_addr", 32'(bm_addr), 32'(e_addr));
                check("bm_wdata", bm_wdata, e_wdata);
            end
            if (bm_req) cnt_req++;
            if (bm_req && bm_we) cnt_wreq++;
            if (cache_hit) begin
                cnt_hit++;
                hit_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        e_busy = 1'b0; e_hit = 1'b0; e_req = 1'b0; e_we = 1'b0;
    endtask

    task automatic junk_inputs();
        re       = 1'($urandom % 2);
        we       = 1'($urandom % 2);
        addr     = ADDR_W'($urandom);
        mem_data = $urandom;
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
        e_result = '0;
    endtask

    // One full transaction starting in an IDLE cycle; returns the cycle the
    // request was presented so callers can measure latency.
    task automatic txn(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [31:0] d, input int dly, input logic [31:0] rdata,
                       input bit spur, output int c0);
        int idx;
        bit hit;
        idx = int'(a) % LINES;
        c0 = cyc;
        cnt_req = 0; cnt_wreq = 0; cnt_hit = 0; hit_cyc = -1;
        idle_exp();
        re = rd; we = wr; addr = a; mem_data = d;
        bm_ack = spur ? 1'($urandom % 2) : 1'b0;
        step();
        junk_inputs();
        bm_ack = spur ? 1'($urandom % 2) : 1'b0;
        e_busy = 1'b1;
        hit = c_CACHE && !wr && mv[idx] && (ma[idx] == a);
        step();
        if (!hit) begin
            e_req = 1'b1; e_we = wr; e_addr = a; e_wdata = d;
            for (int k = 1; k <= dly; k++) begin
                junk_inputs();
                bm_ack   = (k == dly);
                bm_rdata = (k == dly) ? rdata : $urandom;
                step();
            end
            e_req = 1'b0; e_we = 1'b0;
            if (!wr) e_result = rdata;
            if (c_CACHE) begin
                if (!wr) begin
                    mv[idx] = 1'b1; ma[idx] = a; md[idx] = rdata;
                end else if (mv[idx] && ma[idx] == a) begin
                    md[idx] = d;
                end
            end
        end else begin
            e_result = md[idx];
        end
        e_hit = 1'b1;
        junk_inputs();
        bm_ack = spur ? 1'($urandom % 2) : 1'b0;
        step();
        idle_exp();
        re = 1'b0; we = 1'b0; bm_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int c0;
        logic [ADDR_W-1:0] a;
        int r;
        model_clear();
        idle_exp();
        chk_en = 1'b1;
        step();
        step();
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_result", mem_result, 32'h0);
        rst_n = 1'b1;
        step();

        // Cold read: three cycles of bm_req, one completion
        txn(1, 0, 22'h000005, 32'h0, 3, 32'hDEADBEEF, 0, c0);
        check("cold_req_cycles", 32'(cnt_req), 32'd3);
        check("cold_hits", 32'(cnt_hit), 32'd1);
        check("cold_result", mem_result, 32'hDEADBEEF);

        // Repeat read: with the cache, completes in the second cycle after acceptance
        txn(1, 0, 22'h000005, 32'h0, 2, 32'hDEADBEEF, 0, c0);
        check("repeat_req_cycles", 32'(cnt_req), c_CACHE ? 32'd0 : 32'd2);
        check("repeat_latency", 32'(hit_cyc - c0), c_CACHE ? 32'd2 : 32'd4);
        check("repeat_result", mem_result, 32'hDEADBEEF);

        // Write-through then read back
        txn(0, 1, 22'h000005, 32'h12345678, 2, 32'h0, 0, c0);
        check("wr_we_cycles", 32'(cnt_wreq), 32'd2);
        check("wr_result_held", mem_result, 32'hDEADBEEF);
        txn(1, 0, 22'h000005, 32'h0, 2, 32'h12345678, 0, c0);
        check("wr_readback_req", 32'(cnt_req), c_CACHE ? 32'd0 : 32'd2);
        check("wr_readback", mem_result, 32'h12345678);

        // Index aliasing: 0x0D evicts 0x05
        txn(1, 0, 22'h000005, 32'h0, 2, 32'h12345678, 0, c0);
        txn(1, 0, 22'h00000D, 32'h0, 2, 32'h0D0D0D0D, 0, c0);
        check("alias_d_req", 32'(cnt_req), 32'd2);
        txn(1, 0, 22'h000005, 32'h0, 2, 32'h55555555, 0, c0);
        check("alias_5_req", 32'(cnt_req), 32'd2);
        check("alias_5_result", mem_result, 32'h55555555);

        // Reset in the middle of BM_WAIT, then a stale ack
        mem_data = 32'h0;
        re = 1'b1; addr = 22'h000025;
        step();
        re = 1'b0; e_busy = 1'b1;
        step();
        e_req = 1'b1; e_we = 1'b0; e_addr = 22'h000025; e_wdata = 32'h0;
        step();
        rst_n = 1'b0;
        idle_exp();
        model_clear();
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_bm_req", 32'(bm_req), 32'h0);
        check("rst_bm_addr", 32'(bm_addr), 32'h0);
        check("rst_bm_wdata", bm_wdata, 32'h0);
        check("rst_result", mem_result, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        bm_ack = 1'b1; bm_rdata = 32'hBADBAD00;
        step();
        bm_ack = 1'b0;
        step();
        txn(1, 0, 22'h000005, 32'h0, 2, 32'hCAFEF00D, 0, c0);
        check("post_rst_req", 32'(cnt_req), 32'd2);
        check("post_rst_result", mem_result, 32'hCAFEF00D);

        // re and we together act as a write
        txn(1, 1, 22'h000010, 32'hA5A5A5A5, 2, 32'h0, 0, c0);
        check("rw_we_cycles", 32'(cnt_wreq), 32'd2);
        check("rw_hits", 32'(cnt_hit), 32'd1);
        check("rw_result_held", mem_result, 32'hCAFEF00D);

        // Randomized traffic over a few aliasing tags
        for (int n = 0; n < 250; n++) begin
            r = int'($urandom % 3);
            a = ADDR_W'((r == 2 ? 32'h7FFFF : 32'(r)) << 3) | ADDR_W'($urandom % LINES);
            r = int'($urandom % 4);
            txn(r != 2, r >= 2, a, $urandom, int'($urandom_range(1, 4)), $urandom, 1, c0);
            for (int g = int'($urandom % 3); g > 0; g--) begin
                bm_ack = 1'($urandom % 2);
                step();
            end
            bm_ack = 1'b0;
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
